vx_commit_arbiter: RTL and testbench
====================================

VX_COMMIT_ARBITER -- requirements
Module: VX_commit_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4: number of commit sources (index 0 = ALU, 1 = LSU, 2 = CSR, 3 = MUL/FPU).
REQ-002 SHALL have parameter NUM_THREADS, default 4: lanes per commit.
REQ-003 SHALL have parameter NW_BITS, default 2: warp-id width.
REQ-004 SHALL have parameter NR_BITS, default 5: register-id width.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 req_valid  in  NUM_REQS  per-source commit valid.
REQ-009 req_wid  in  NUM_REQS*NW_BITS  warp id.
REQ-010 req_tmask  in  NUM_REQS*NUM_THREADS  thread mask.
REQ-011 req_PC  in  NUM_REQS*32  instruction PC.
REQ-012 req_rd  in  NUM_REQS*NR_BITS  destination register.
REQ-013 req_wb  in  NUM_REQS  register-write enable.
REQ-014 req_data  in  NUM_REQS*NUM_THREADS*32  per-lane result.
REQ-015 req_eop  in  NUM_REQS  last beat of a commit packet.
REQ-016 req_ready  out  NUM_REQS  per-source accept.
REQ-017 wb_valid, wb_wid, wb_tmask, wb_PC, wb_rd, wb_wb, wb_data, wb_eop  out  widths as inputs  registered writeback beat.
REQ-018 wb_ready  in  1  downstream (register file / scoreboard) accept.

Function
REQ-019 SHALL transfer an input beat only when req_valid[i] && req_ready[i]; an output beat only when wb_valid && wb_ready.
REQ-020 SHALL assert req_ready only for the granted source, and only when the output register is empty or draining (~wb_valid || wb_ready); all other req_ready bits 0.
REQ-021 SHALL have latency exactly 1 cycle: beat accepted at edge N appears on wb_* after edge N, unchanged until accepted.
REQ-022 SHALL hold all wb_* stable while wb_valid && !wb_ready.
REQ-023 Arbiter states: IDLE (no lock) and LOCKED(src); IDLE grants the first valid source at or after rr_ptr, wrapping modulo NUM_REQS.
REQ-024 Accepted beat with req_eop=0: enter LOCKED(src); only src may be granted until its eop beat is accepted.
REQ-025 In LOCKED(src) with req_valid[src]=0: no grant, no output beat; other sources stay stalled (no interleaving of packets).
REQ-026 Accepted beat with req_eop=1: return to IDLE; rr_ptr <= (src+1) mod NUM_REQS.
REQ-027 No accepted beat: rr_ptr and lock unchanged.
REQ-028 All sources valid continuously, each single-beat: grants in order 0,1,2,3,0,... one per cycle at full throughput when wb_ready=1.
REQ-029 Beats with req_wb=0 SHALL still be forwarded (retirement tracking); wb_wb carries the flag.
REQ-030 NUM_REQS=1: arbiter degenerates to a pipe register; lock still tracked.

Reset
REQ-031 On reset: wb_valid=0, rr_ptr=0, state IDLE; other wb_* fields SHALL be don't-care (not reset).
REQ-032 Reset mid-packet SHALL drop the lock; the first post-reset grant follows REQ-023 from rr_ptr=0.
REQ-033 req_ready SHALL be 0 on every cycle where reset=1.

Configuration
REQ-034 Macro COMMIT_ARB_PERF_EN defined: add outputs perf_commits (32-bit, +1 per accepted output beat with wb_eop=1) and perf_stalls (32-bit, +1 per cycle with wb_valid && !wb_ready); both reset to 0 and wrap at 2^32.
REQ-035 Macro undefined: perf ports and counters SHALL be absent; behaviour otherwise identical.

Verification
REQ-036 Reset, then req_valid=4'b1111 single-beat each, wb_ready=1 -> wb_wid sequence from sources 0,1,2,3 in consecutive cycles, first wb_valid one cycle after the first accept.
REQ-037 LSU (src 1) 3-beat packet (eop on beat 3) with ALU valid throughout -> wb shows src1,src1,src1 then src0; req_ready[0]=0 during the packet.
REQ-038 wb_ready=0 for 5 cycles with wb_valid=1, PC=0x80000010 -> wb_* unchanged, all req_ready=0; perf_stalls=5 (COMMIT_ARB_PERF_EN).
REQ-039 LSU packet: beat 1 accepted, req_valid[1]=0 for 3 cycles while src 2 valid -> no output beats, src 2 not granted until src1 eop accepted.
REQ-040 Reset asserted mid-packet (after beat 1 of 2) -> wb_valid=0 next cycle; after release with src 0 and 1 valid, src 0 granted first.
REQ-041 Commit with req_wb=0, tmask=4'b0101 -> forwarded with wb_wb=0, wb_tmask=4'b0101; perf_commits +1.

Source files
------------

// File: rtl/vx_commit_arbiter.sv
// Commit arbiter: round-robin over NUM_REQS sources with packet locking and one registered writeback beat.
// Define COMMIT_ARB_PERF_EN to add the perf_commits / perf_stalls counters.
module vx_commit_arbiter #(
    parameter int NUM_REQS    = 4,
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQS-1:0]               req_valid,
    input  logic [NUM_REQS*NW_BITS-1:0]       req_wid,
    input  logic [NUM_REQS*NUM_THREADS-1:0]   req_tmask,
    input  logic [NUM_REQS*32-1:0]            req_PC,
    input  logic [NUM_REQS*NR_BITS-1:0]       req_rd,
    input  logic [NUM_REQS-1:0]               req_wb,
    input  logic [NUM_REQS*NUM_THREADS*32-1:0] req_data,
    input  logic [NUM_REQS-1:0]               req_eop,
    output logic [NUM_REQS-1:0]               req_ready,
    output logic                              wb_valid,
    output logic [NW_BITS-1:0]                wb_wid,
    output logic [NUM_THREADS-1:0]            wb_tmask,
    output logic [31:0]                       wb_PC,
    output logic [NR_BITS-1:0]                wb_rd,
    output logic                              wb_wb,
    output logic [NUM_THREADS*32-1:0]         wb_data,
    output logic                              wb_eop,
    input  logic                              wb_ready
`ifdef COMMIT_ARB_PERF_EN
    ,
    output logic [31:0]                       perf_commits,
    output logic [31:0]                       perf_stalls
`endif
);

    localparam int SRC_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int DATA_W = NUM_THREADS * 32;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

    state_e             state_q;
    logic [SRC_W-1:0]   lock_src_q;
    logic [SRC_W-1:0]   rr_ptr_q;
    logic               wb_valid_q;
    logic [NW_BITS-1:0] wb_wid_q;
    logic [NUM_THREADS-1:0] wb_tmask_q;
    logic [31:0]        wb_pc_q;
    logic [NR_BITS-1:0] wb_rd_q;
    logic               wb_wb_q;
    logic [DATA_W-1:0]  wb_data_q;
    logic               wb_eop_q;

    logic               grant_valid;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W-1:0]   cand;
    logic [SRC_W-1:0]   rr_next;
    int                 idx;
    logic               out_ready;
    logic               accept;

    logic [NW_BITS-1:0]     sel_wid;
    logic [NUM_THREADS-1:0] sel_tmask;
    logic [31:0]            sel_pc;
    logic [NR_BITS-1:0]     sel_rd;
    logic                   sel_wb;
    logic [DATA_W-1:0]      sel_data;
    logic                   sel_eop;

    // Locked: only the owner may proceed. Idle: descending scan so the lowest offset from rr_ptr wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        idx         = 0;
        if (state_q == ST_LOCKED) begin
            grant_valid = req_valid[lock_src_q];
            grant_idx   = lock_src_q;
        end else begin
            for (int i = NUM_REQS - 1; i >= 0; i--) begin
                idx  = (int'(rr_ptr_q) + i) % NUM_REQS;
                cand = SRC_W'(idx);
                if (req_valid[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    assign out_ready = !wb_valid_q || wb_ready;
    assign accept    = grant_valid && out_ready && !reset;
    assign rr_next   = (grant_idx == SRC_W'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        sel_wid   = '0;
        sel_tmask = '0;
        sel_pc    = '0;
        sel_rd    = '0;
        sel_wb    = 1'b0;
        sel_data  = '0;
        sel_eop   = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant_idx == SRC_W'(i)) begin
                sel_wid   = req_wid[i*NW_BITS +: NW_BITS];
                sel_tmask = req_tmask[i*NUM_THREADS +: NUM_THREADS];
                sel_pc    = req_PC[i*32 +: 32];
                sel_rd    = req_rd[i*NR_BITS +: NR_BITS];
                sel_wb    = req_wb[i];
                sel_data  = req_data[i*DATA_W +: DATA_W];
                sel_eop   = req_eop[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            lock_src_q <= '0;
            rr_ptr_q   <= '0;
            wb_valid_q <= 1'b0;
        end else if (accept) begin
            wb_valid_q <= 1'b1;
            lock_src_q <= grant_idx;
            if (sel_eop) begin
                state_q  <= ST_IDLE;
                rr_ptr_q <= rr_next;
            end else begin
                state_q  <= ST_LOCKED;
            end
        end else if (wb_ready) begin
            wb_valid_q <= 1'b0;
        end
    end

    // NOTE: payload registers carry no reset; wb_valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (accept) begin
            wb_wid_q   <= sel_wid;
            wb_tmask_q <= sel_tmask;
            wb_pc_q    <= sel_pc;
            wb_rd_q    <= sel_rd;
            wb_wb_q    <= sel_wb;
            wb_data_q  <= sel_data;
            wb_eop_q   <= sel_eop;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_wid   = wb_wid_q;
    assign wb_tmask = wb_tmask_q;
    assign wb_PC    = wb_pc_q;
    assign wb_rd    = wb_rd_q;
    assign wb_wb    = wb_wb_q;
    assign wb_data  = wb_data_q;
    assign wb_eop   = wb_eop_q;

`ifdef COMMIT_ARB_PERF_EN
    logic [31:0] perf_commits_q;
    logic [31:0] perf_stalls_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_commits_q <= '0;
            perf_stalls_q  <= '0;
        end else begin
            if (wb_valid_q && wb_ready && wb_eop_q) perf_commits_q <= perf_commits_q + 32'd1;
            if (wb_valid_q && !wb_ready)            perf_stalls_q  <= perf_stalls_q + 32'd1;
        end
    end

    assign perf_commits = perf_commits_q;
    assign perf_stalls  = perf_stalls_q;
`else
    // Counters absent; arbitration and writeback behave identically.
`endif

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Scoreboard bench for vx_commit_arbiter: a driver predicts grants from the arbitration rules and
// queues expected beats; a negedge monitor pops and compares each accepted writeback beat.
module tb_vx_commit_arbiter;

    localparam int N  = 4;
    localparam int T  = 4;
    localparam int NW = 2;
    localparam int NR = 5;
    localparam int DW = T * 32;
    localparam int CW = 256;

    typedef logic [CW-1:0] cw_t;

    typedef struct packed {
        logic [NW-1:0] wid;
        logic [T-1:0]  tmask;
        logic [31:0]   pc;
        logic [NR-1:0] rd;
        logic          wb;
        logic [DW-1:0] data;
        logic          eop;
    } beat_t;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*NW-1:0] req_wid;
    logic [N*T-1:0]  req_tmask;
    logic [N*32-1:0] req_PC;
    logic [N*NR-1:0] req_rd;
    logic [N-1:0]    req_wb;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_eop;
    logic [N-1:0]    req_ready;
    logic            wb_valid;
    logic [NW-1:0]   wb_wid;
    logic [T-1:0]    wb_tmask;
    logic [31:0]     wb_PC;
    logic [NR-1:0]   wb_rd;
    logic            wb_wb;
    logic [DW-1:0]   wb_data;
    logic            wb_eop;
    logic            wb_ready;
`ifdef COMMIT_ARB_PERF_EN
    logic [31:0]     perf_commits;
    logic [31:0]     perf_stalls;
`endif

    vx_commit_arbiter #(.NUM_REQS(N), .NUM_THREADS(T), .NW_BITS(NW), .NR_BITS(NR)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_wid(req_wid), .req_tmask(req_tmask), .req_PC(req_PC),
        .req_rd(req_rd), .req_wb(req_wb), .req_data(req_data), .req_eop(req_eop),
        .req_ready(req_ready),
        .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_tmask(wb_tmask), .wb_PC(wb_PC),
        .wb_rd(wb_rd), .wb_wb(wb_wb), .wb_data(wb_data), .wb_eop(wb_eop),
        .wb_ready(wb_ready)
`ifdef COMMIT_ARB_PERF_EN
        , .perf_commits(perf_commits), .perf_stalls(perf_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input cw_t act, input cw_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pending beats per source, and expected writeback beats in order.
    beat_t src_q [N][$];
    beat_t exp_q [$];

    // Reference state: locked owner (-1 = none), round-robin pointer, output register occupancy.
    int m_lock = -1;
    int m_rr   = 0;
    bit m_full = 1'b0;

    function automatic beat_t rand_beat(input bit eop);
        beat_t b;
        b       = '0;
        b.wid   = NW'($urandom);
        b.tmask = T'($urandom);
        b.pc    = $urandom;
        b.rd    = NR'($urandom);
        b.wb    = 1'($urandom);
        for (int k = 0; k < T; k++) b.data[k*32 +: 32] = $urandom;
        b.eop   = eop;
        return b;
    endfunction

    task automatic push_pkt(input int s, input int len);
        for (int k = 0; k < len; k++) src_q[s].push_back(rand_beat(k == len - 1));
    endtask

    // Owner if locked; otherwise first valid source walking up from the pointer, modulo N.
    function automatic int pick(input logic [N-1:0] v);
        int s;
        if (m_lock >= 0) return v[m_lock] ? m_lock : -1;
        for (int k = 0; k < N; k++) begin
            s = (m_rr + k) % N;
            if (v[s]) return s;
        end
        return -1;
    endfunction

    // One cycle: present inputs, check req_ready against the model, step the model across the edge.
    task automatic drive(input logic [N-1:0] want, input logic wbr, output logic [N-1:0] seen);
        logic [N-1:0] v;
        logic [N-1:0] exp_rdy;
        beat_t        b;
        int           g;
        v = '0;
        for (int s = 0; s < N; s++) begin
            if (want[s] && src_q[s].size() > 0) begin
                v[s] = 1'b1;
                b    = src_q[s][0];
            end else begin
                b    = rand_beat(1'($urandom));
            end
            req_wid[s*NW +: NW]  = b.wid;
            req_tmask[s*T +: T]  = b.tmask;
            req_PC[s*32 +: 32]   = b.pc;
            req_rd[s*NR +: NR]   = b.rd;
            req_wb[s]            = b.wb;
            req_data[s*DW +: DW] = b.data;
            req_eop[s]           = b.eop;
        end
        req_valid = v;
        wb_ready  = wbr;
        #1;
        g = -1;
        if (!m_full || wbr) g = pick(v);
        exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
        seen    = req_ready;
        check("req_ready", cw_t'(req_ready), cw_t'(exp_rdy));
        if (g >= 0) begin
            b = src_q[g].pop_front();
            exp_q.push_back(b);
            if (b.eop) begin
                m_lock = -1;
                m_rr   = (g + 1) % N;
            end else begin
                m_lock = g;
            end
        end
        m_full = (g >= 0) || (m_full && !wbr);
        @(posedge clk);
        #1;
        check("wb_valid", cw_t'(wb_valid), cw_t'(m_full));
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '1;
        wb_ready  = 1'b0;
        #1;
        check("req_ready_in_reset", cw_t'(req_ready), '0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = '0;
        check("wb_valid_after_reset", cw_t'(wb_valid), '0);
        m_lock = -1;
        m_rr   = 0;
        m_full = 1'b0;
        exp_q.delete();
        for (int s = 0; s < N; s++) src_q[s].delete();
    endtask

    // Monitor: compares every accepted beat and checks wb_* hold steady through stalls.
    bit  hold = 1'b0;
    cw_t snap;
    initial begin
        beat_t e;
        cw_t   cur;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold = 1'b0;
            end else begin
                cur = cw_t'({wb_wid, wb_tmask, wb_PC, wb_rd, wb_wb, wb_data, wb_eop});
                if (hold) begin
                    check("wb_hold_valid", cw_t'(wb_valid), cw_t'(1));
                    check("wb_hold_fields", cur, snap);
                end
                if (wb_valid && wb_ready) begin
                    if (exp_q.size() == 0) begin
                        check("sb_beat_expected", cw_t'(exp_q.size()), cw_t'(1));
                    end else begin
                        e = exp_q.pop_front();
                        check("wb_beat", cur, cw_t'(e));
                    end
                end
                hold = (wb_valid === 1'b1) && (wb_ready === 1'b0);
                snap = cur;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] r;
        beat_t        b;
        int           left;
`ifdef COMMIT_ARB_PERF_EN
        logic [31:0]  p0;
`endif
        reset     = 1'b1;
        req_valid = '0;
        req_wid   = '0;
        req_tmask = '0;
        req_PC    = '0;
        req_rd    = '0;
        req_wb    = '0;
        req_data  = '0;
        req_eop   = '0;
        wb_ready  = 1'b0;
        do_reset();
        do_reset();

        // All four single-beat sources valid: grants 0,1,2,3 back to back.
        for (int s = 0; s < N; s++) begin
            b     = rand_beat(1'b1);
            b.wid = NW'(s);
            src_q[s].push_back(b);
        end
        for (int k = 0; k < N; k++) begin
            drive('1, 1'b1, r);
            check("rr_grant", cw_t'(r), cw_t'(N'(1) << k));
            check("rr_wid", cw_t'(wb_wid), cw_t'(k));
        end
        drive('0, 1'b1, r);

        // LSU three-beat packet locks out the ALU.
        do_reset();
        push_pkt(1, 3);
        push_pkt(0, 1);
        push_pkt(0, 1);
        drive(4'b0010, 1'b1, r);
        check("lock_beat1", cw_t'(r), cw_t'(4'b0010));
        drive(4'b0011, 1'b1, r);
        check("lock_beat2", cw_t'(r), cw_t'(4'b0010));
        drive(4'b0011, 1'b1, r);
        check("lock_beat3", cw_t'(r), cw_t'(4'b0010));
        drive(4'b0011, 1'b1, r);
        check("after_lock_alu", cw_t'(r), cw_t'(4'b0001));
        drive('0, 1'b1, r);

        // Five-cycle downstream stall holds the beat and blocks all sources.
        do_reset();
        b    = rand_beat(1'b1);
        b.pc = 32'h8000_0010;
        src_q[0].push_back(b);
        push_pkt(1, 1);
        drive(4'b0001, 1'b1, r);
`ifdef COMMIT_ARB_PERF_EN
        p0 = perf_stalls;
`endif
        for (int k = 0; k < 5; k++) begin
            drive(4'b0010, 1'b0, r);
            check("stall_ready", cw_t'(r), '0);
            check("stall_pc", cw_t'(wb_PC), cw_t'(32'h8000_0010));
        end
`ifdef COMMIT_ARB_PERF_EN
        check("perf_stalls", cw_t'(perf_stalls - p0), cw_t'(5));
`endif
        drive(4'b0010, 1'b1, r);
        drive('0, 1'b1, r);

        // Locked owner goes idle: no output, CSR stays stalled until the eop beat.
        do_reset();
        push_pkt(1, 2);
        push_pkt(2, 1);
        drive(4'b0010, 1'b1, r);
        for (int k = 0; k < 3; k++) begin
            drive(4'b0100, 1'b1, r);
            check("owner_gap_ready", cw_t'(r), '0);
        end
        drive(4'b0110, 1'b1, r);
        check("owner_eop", cw_t'(r), cw_t'(4'b0010));
        drive(4'b0100, 1'b1, r);
        check("csr_after_eop", cw_t'(r), cw_t'(4'b0100));
        drive('0, 1'b1, r);

        // Reset mid-packet drops the lock; arbitration restarts at source 0.
        do_reset();
        push_pkt(1, 2);
        drive(4'b0010, 1'b1, r);
        do_reset();
        push_pkt(0, 1);
        push_pkt(1, 1);
        drive(4'b0011, 1'b1, r);
        check("post_reset_first", cw_t'(r), cw_t'(4'b0001));
        drive(4'b0011, 1'b1, r);
        check("post_reset_second", cw_t'(r), cw_t'(4'b0010));
        drive('0, 1'b1, r);

        // Non-writing commit is still forwarded.
        do_reset();
        b       = rand_beat(1'b1);
        b.wb    = 1'b0;
        b.tmask = 4'b0101;
        src_q[2].push_back(b);
`ifdef COMMIT_ARB_PERF_EN
        p0 = perf_commits;
`endif
        drive(4'b0100, 1'b1, r);
        check("nowb_wb", cw_t'(wb_wb), '0);
        check("nowb_tmask", cw_t'(wb_tmask), cw_t'(4'b0101));
        drive('0, 1'b1, r);
`ifdef COMMIT_ARB_PERF_EN
        check("perf_commits", cw_t'(perf_commits - p0), cw_t'(1));
`endif

        // Randomized traffic: multi-beat packets, sporadic valids, back-pressure.
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int s = 0; s < N; s++)
                if (src_q[s].size() == 0 && ($urandom % 3) == 0) push_pkt(s, 1 + int'($urandom % 3));
            drive(N'($urandom), ($urandom % 10) < 7, r);
        end
        for (int k = 0; k < 300; k++) begin
            left = 0;
            for (int s = 0; s < N; s++) left += src_q[s].size();
            if (left == 0) break;
            drive('1, 1'b1, r);
        end
        left = 0;
        for (int s = 0; s < N; s++) left += src_q[s].size();
        check("sources_drained", cw_t'(left), '0);
        drive('0, 1'b1, r);
        drive('0, 1'b1, r);
        check("scoreboard_empty", cw_t'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
